// File: rtl/registered_mux_n.sv
// registered_mux_n: N-to-1 data multiplexer with a registered output, stall hold, flush, valid tracking and selector range check
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   Enable     1 = capture a new selection, 0 = hold
//   Flush      1 = clear the output stage (bubble)
//   In_Valid   qualifies the selection presented this cycle
//   Selector   index of the data input to forward
//   MUX_Data   packed inputs, input k at [k*NBits +: NBits]
//   MUX_Output registered selected data
//   Out_Valid  MUX_Output holds a valid selection
//   Sel_Error  last captured selection used an out-of-range index
//   Err_Count  saturating count of valid out-of-range captures (only with REGISTERED_MUX_ERRCNT_EN)
module registered_mux_n #(
    parameter int NBits   = 32,
    parameter int NInputs = 4,
    parameter int SelBits = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Enable,
    input  logic                       Flush,
    input  logic                       In_Valid,
    input  logic [SelBits-1:0]         Selector,
    input  logic [NInputs*NBits-1:0]   MUX_Data,
    output logic [NBits-1:0]           MUX_Output,
    output logic                       Out_Valid,
`ifdef REGISTERED_MUX_ERRCNT_EN
    output logic                       Sel_Error,
    output logic [7:0]                 Err_Count
`else
    output logic                       Sel_Error
`endif
);
    logic [NBits-1:0] r_out;
    logic             r_valid;
    logic             r_err;
    logic [NBits-1:0] w_sel_data;
    logic             w_in_range;
    // One extra bit so NInputs == 2^SelBits is representable in the compare
    assign w_in_range = {1'b0, Selector} < (SelBits+1)'(NInputs);
    // Out-of-range selectors fall through to input 0
    always_comb begin
        w_sel_data = MUX_Data[NBits-1:0];
        for (int k = 1; k < NInputs; k++)
            if (Selector == SelBits'(k)) w_sel_data = MUX_Data[k*NBits +: NBits];
    end
    always_ff @(posedge clk) begin
        if (!reset || Flush) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (Enable) begin
            r_out   <= w_sel_data;
            r_valid <= In_Valid;
            r_err   <= ~w_in_range;
        end
    end
    assign MUX_Output = r_out;
    assign Out_Valid  = r_valid;
    assign Sel_Error  = r_err;
`ifdef REGISTERED_MUX_ERRCNT_EN
    logic [7:0] r_err_cnt;
    // Flush deliberately does not clear the count
    always_ff @(posedge clk) begin
        if (!reset)
            r_err_cnt <= 8'h00;
        else if (Enable && !Flush && In_Valid && !w_in_range && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'h01;
    end
    assign Err_Count = r_err_cnt;
`endif
endmodule

// File: tb/tb_registered_mux_n.sv
// tb_registered_mux_n: table-driven and directed checks of registered_mux_n
module tb_registered_mux_n;
    localparam logic [127:0] DATA = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    logic         clk = 1'b0;
    logic         reset, en, fl, iv;
    logic [3:0]   sel;
    logic [1:0]   sel3;
    logic [127:0] data;
    logic [31:0]  out, out3, outf;
    logic         ov, ov3, ovf, se, se3, sef;
    logic [7:0]   ec, ec3, ecf;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    registered_mux_n #(.NBits(32), .NInputs(4), .SelBits(4)) u_dut (
        .clk(clk), .reset(reset), .Enable(en), .Flush(fl), .In_Valid(iv),
        .Selector(sel), .MUX_Data(data), .MUX_Output(out), .Out_Valid(ov),
`ifdef REGISTERED_MUX_ERRCNT_EN
        .Sel_Error(se), .Err_Count(ec)
`else
        .Sel_Error(se)
`endif
    );

    registered_mux_n #(.NBits(32), .NInputs(3), .SelBits(2)) u_dut3 (
        .clk(clk), .reset(reset), .Enable(en), .Flush(fl), .In_Valid(iv),
        .Selector(sel3), .MUX_Data(data[95:0]), .MUX_Output(out3), .Out_Valid(ov3),
`ifdef REGISTERED_MUX_ERRCNT_EN
        .Sel_Error(se3), .Err_Count(ec3)
`else
        .Sel_Error(se3)
`endif
    );

    registered_mux_n #(.NBits(32), .NInputs(4), .SelBits(2)) u_full (
        .clk(clk), .reset(reset), .Enable(en), .Flush(fl), .In_Valid(iv),
        .Selector(sel[1:0]), .MUX_Data(data), .MUX_Output(outf), .Out_Valid(ovf),
`ifdef REGISTERED_MUX_ERRCNT_EN
        .Sel_Error(sef), .Err_Count(ecf)
`else
        .Sel_Error(sef)
`endif
    );

`ifndef REGISTERED_MUX_ERRCNT_EN
    assign ec  = 8'h00;
    assign ec3 = 8'h00;
    assign ecf = 8'h00;
`endif

    typedef struct {
        logic        rst_n, en, fl, iv;
        logic [3:0]  sel;
        logic [31:0] e_out;
        logic        e_v, e_err;
        logic [7:0]  e_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic f, input logic v, input logic [3:0] s);
        reset = r; en = e; fl = f; iv = v; sel = s;
        @(posedge clk);
        #1;
    endtask

    vec_t vt[17];

    initial begin
        vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd2,  32'h0,        1'b0, 1'b0, 8'd0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd2,  32'h0,        1'b0, 1'b0, 8'd0};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd2,  32'h33333333, 1'b1, 1'b0, 8'd0};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  32'h11111111, 1'b1, 1'b0, 8'd0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1,  32'h22222222, 1'b1, 1'b0, 8'd0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd2,  32'h33333333, 1'b1, 1'b0, 8'd0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  32'h44444444, 1'b1, 1'b0, 8'd0};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1,  32'h22222222, 1'b1, 1'b0, 8'd0};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd3,  32'h0,        1'b0, 1'b0, 8'd0};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  32'h44444444, 1'b1, 1'b0, 8'd0};
        vt[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd5,  32'h11111111, 1'b1, 1'b1, 8'd1};
        vt[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1,  32'h22222222, 1'b1, 1'b0, 8'd1};
        vt[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 32'h11111111, 1'b0, 1'b1, 8'd1};
        vt[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd2,  32'h11111111, 1'b0, 1'b1, 8'd1};
        vt[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  32'h0,        1'b0, 1'b0, 8'd1};
        vt[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd4,  32'h11111111, 1'b1, 1'b1, 8'd2};
        vt[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd4,  32'h0,        1'b0, 1'b0, 8'd0};

        data = DATA; sel3 = 2'd0;
        for (int i = 0; i < 17; i++) begin
            step(vt[i].rst_n, vt[i].en, vt[i].fl, vt[i].iv, vt[i].sel);
            chk($sformatf("vec%0d out", i), out, vt[i].e_out);
            chk($sformatf("vec%0d valid", i), 32'(ov), 32'(vt[i].e_v));
            chk($sformatf("vec%0d sel_err", i), 32'(se), 32'(vt[i].e_err));
            chk($sformatf("vec%0d full_range_err", i), 32'(sef), 32'h0);
`ifdef REGISTERED_MUX_ERRCNT_EN
            chk($sformatf("vec%0d err_cnt", i), 32'(ec), 32'(vt[i].e_cnt));
`endif
        end

        // stall hold while selector and data change
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd1);
        chk("stall capture", out, 32'h22222222);
        for (int i = 0; i < 5; i++) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
            chk($sformatf("stall%0d out", i), out, 32'h22222222);
            chk($sformatf("stall%0d valid", i), 32'(ov), 32'h1);
        end
        data = DATA;

        // reset asserted mid-stall, then resume on next Enable
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd2);
        chk("pre-reset capture", out, 32'h33333333);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        chk("mid-stall reset out", out, 32'h0);
        chk("mid-stall reset valid", 32'(ov), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        chk("post-reset hold out", out, 32'h0);
        chk("post-reset hold valid", 32'(ov), 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
        chk("resume out", out, 32'h11111111);
        chk("resume valid", 32'(ov), 32'h1);

        // NInputs=3 instance: index 3 is out of range
        sel3 = 2'd3;
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
        chk("n3 bad out", out3, 32'h11111111);
        chk("n3 bad err", 32'(se3), 32'h1);
        chk("n3 bad valid", 32'(ov3), 32'h1);
        sel3 = 2'd1;
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
        chk("n3 good out", out3, 32'h22222222);
        chk("n3 good err", 32'(se3), 32'h0);
        sel3 = 2'd2;
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
        chk("n3 top out", out3, 32'h33333333);
        chk("n3 top err", 32'(se3), 32'h0);

`ifdef REGISTERED_MUX_ERRCNT_EN
        // saturation of the error counter
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("cnt reset", 32'(ec), 32'h0);
        for (int i = 0; i < 254; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 4'd9);
        chk("cnt 254", 32'(ec), 32'hFE);
        for (int i = 0; i < 46; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 4'd9);
        chk("cnt saturate", 32'(ec), 32'hFF);
        chk("n3 cnt", 32'(ec3), 32'h0);
        chk("full cnt", 32'(ecf), 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
        chk("cnt after flush", 32'(ec), 32'hFF);
        chk("flush err", 32'(se), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("cnt mid reset", 32'(ec), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/registered_mux_n.md
Name: registered_mux_n

Overview:
- Parametrised N-to-1 data multiplexer with a registered output stage for the pipelined RISC-V datapath.
- Used at pipeline-register boundaries such as the forwarding selects ahead of the ALU operands and the writeback source select.
- Adds stall hold, flush, valid tracking and out-of-range selector detection.
- Latency is one clock from select/data to output.

Parameters:
- NBits, 32, width of each data input and of the output.
- NInputs, 4, number of data inputs; legal range 2..16.
- SelBits, 4, selector width; must satisfy 2^SelBits >= NInputs.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-low reset.
- Enable  input  1  1 = capture a new selection this cycle; 0 = stall (hold).
- Flush  input  1  1 = clear the output stage (bubble insertion).
- In_Valid  input  1  qualifies the selection presented this cycle.
- Selector  input  SelBits  index of the data input to forward.
- MUX_Data  input  NInputs*NBits  packed inputs; input k occupies bits [k*NBits +: NBits].
- MUX_Output  output  NBits  registered selected data.
- Out_Valid  output  1  MUX_Output holds a valid selection.
- Sel_Error  output  1  registered flag: the last captured selection used an out-of-range index.

Behaviour:
- All state updates on the rising edge of clk. reset is sampled only on that edge.
- Reset (reset==0): MUX_Output=0, Out_Valid=0, Sel_Error=0. Takes priority over every other input.
- Priority per edge is reset > Flush > Enable > hold.
- Flush==1 (reset high):
  - MUX_Output=0, Out_Valid=0, Sel_Error=0.
  - Enable and In_Valid are ignored that cycle.
- Enable==1, Flush==0:
  - MUX_Output <= input[Selector] when Selector < NInputs.
  - Otherwise MUX_Output <= input 0 and Sel_Error <= 1.
  - Sel_Error <= 0 for an in-range Selector.
  - Out_Valid <= In_Valid.
  - Data and Sel_Error are captured even when In_Valid==0; downstream qualifies them with Out_Valid.
- Enable==0, Flush==0: all outputs hold their previous values for any number of cycles, regardless of Selector/MUX_Data changes.
- Latency: a value presented with Enable=1 at edge n appears on MUX_Output after edge n and stays until the next capturing/flush/reset edge.
- No combinational path from any input to any output.
- NInputs == 2^SelBits: the out-of-range case is unreachable; Sel_Error stays 0 after reset.
- Reset asserted mid-stall: clears outputs on that edge; on deassertion the block resumes normally with the next Enable.
- Flush and Enable both 1: flush wins; that cycle's selection is discarded.

Optional Feature:
- Macro: REGISTERED_MUX_ERRCNT_EN.
- Defined:
  - Adds output port Err_Count [7:0], reset to 0 by reset==0.
  - Increments by 1 on each edge where Enable==1, Flush==0, In_Valid==1 and Selector >= NInputs.
  - Saturates at 8'hFF.
  - Flush does not clear it.
- Not defined: port absent, no counter logic; all other behaviour identical.

Test Plan:
- Reset then release: reset=0 for 2 cycles with MUX_Data inputs 0..3 = 32'h11111111/22222222/33333333/44444444, Selector=2 -> MUX_Output=0, Out_Valid=0, Sel_Error=0. After release with Enable=1, In_Valid=1 -> next edge MUX_Output=32'h33333333, Out_Valid=1.
- Sweep: Selector 0,1,2,3 on consecutive cycles, Enable=1 -> MUX_Output follows 32'h11111111, 22222222, 33333333, 44444444, each one cycle after its select.
- Stall hold: capture Selector=1 (32'h22222222), then Enable=0 for 5 cycles while Selector=3 and the data changes -> MUX_Output stays 32'h22222222 and Out_Valid stays 1 throughout.
- Flush priority: Flush=1 and Enable=1, Selector=3 -> MUX_Output=0, Out_Valid=0. Next cycle Flush=0 -> 32'h44444444 captured.
- Out-of-range with NInputs=3, SelBits=2: Selector=3, Enable=1, In_Valid=1 -> MUX_Output=input 0 value, Sel_Error=1. Next capture with Selector=1 -> Sel_Error=0. With REGISTERED_MUX_ERRCNT_EN: 300 consecutive bad selects -> Err_Count=8'hFF.
- Mid-operation reset: reset=0 asserted during a stall holding 32'h33333333 -> outputs 0 on that edge; Err_Count=0 when the macro is defined.
